conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Streaming producer for the 5x5 convolution datapath: accepts 8-bit MNIST pixels in raster order and emits every valid 5x5 window, packed in the 25x8-bit format the dot-product MAC consumes.
- Built from four row delay lines, a 5x5 window register, column/row counters and a one-entry valid/ready output stage.
- Sits between the pixel source (image RAM/DMA) and the dot-product/max-pool stage.

Parameters:
- IntSize, 8, pixel width in bits
- KSize, 5, kernel edge; ArraySize = KSize*KSize = 25
- ImgW, 28, image width in pixels
- ImgH, 28, image height in pixels

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_pixel  in  IntSize  pixel, raster order, row 0 col 0 first
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- out_window  out  ArraySize*IntSize  packed window; element k at bits [IntSize*k+IntSize-1 : IntSize*k]
- out_valid  out  1  out_window holds an unconsumed window
- out_ready  in  1  consumer accepts out_window this cycle
- out_last  out  1  qualifies out_valid: last window of the frame

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst).
- Reset: out_valid=0, out_last=0, out_window=0, col=0, row=0; in_ready=1 the cycle after reset deasserts. Line buffer contents are not cleared; they are gated by the counters.
- Accept: a pixel is taken when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational; skid-free single stage).
- Counters: col increments per accepted pixel; at col=ImgW-1 it wraps to 0 and row increments; at row=ImgH-1, col=ImgW-1 both wrap to 0, so frames run back-to-back with no gap.
- Window content: when the accepted pixel is at (R,C), element k=r*KSize+c = pixel(R-KSize+1+r, C-KSize+1+c), r,c in 0..KSize-1. Element 0 is the top-left pixel, element 24 is the just-accepted pixel.
- Emission: if R>=KSize-1 and C>=KSize-1, out_window/out_valid are registered on the same edge (latency 1 cycle from acceptance to out_valid). Otherwise no window is produced and out_valid clears if it was consumed this cycle.
- Per frame: (ImgH-KSize+1)*(ImgW-KSize+1) = 576 windows. out_last=1 only with the window at (ImgH-1, ImgW-1).
- Backpressure: while out_valid && !out_ready, out_window and out_last are held stable, in_ready=0, and counters/line buffers are frozen.
- Simultaneous consume + accept: the new window replaces the old one on the same edge, with no bubble.
- Row wrap: the window register is shifted for every pixel, including cols 0..KSize-2; windows that straddle rows are never emitted.
- Reset mid-frame: all in-flight state is discarded and the next accepted pixel is treated as (0,0).
- Arithmetic: counters are clog2(ImgW) and clog2(ImgH) wide with no saturation. Pixels pass through unmodified.

Optional Feature:
- Macro: CONV_WIN_COORD_EN
- Defined: adds output ports out_row [clog2(ImgH)-1:0] and out_col [clog2(ImgW)-1:0]. They carry the top-left pixel coordinate of out_window (R-KSize+1, C-KSize+1), are registered and held with out_window, and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package conv_pkg holds: IntSize, KSize, ArraySize, ImgW, ImgH defaults, the derived counter widths, and the window-element index function (r*KSize+c). The dot-product and pool blocks reuse this package.
- Sub-module line_buffer: a one-row delay of depth ImgW and width IntSize with an enable. It is instantiated KSize-1 times and cascaded, giving the pixels of rows R-1..R-4 at the current column.

Test Plan:
- Full frame, pixel(y,x)=(y*28+x) mod 256, out_ready=1, in_valid=1: the first out_valid arrives 1 cycle after the 117th accepted pixel, with elem0=0, elem4=4, elem20=112, elem24=116.
- Same frame: exactly 576 windows. The 576th has out_last=1 and elem24=(783 mod 256)=15. No out_last on any other window.
- Row boundary: window at (R=4,C=27) has elem24=139. The next emitted window has elem24=144 (R=5,C=4), with no emissions for cols 0..3 of row 5.
- Backpressure: drop out_ready for 10 cycles while out_valid=1 -> out_window stable, in_ready=0, no pixels lost. The window stream is identical to the no-stall run.
- Reset after 300 accepted pixels, then a fresh frame -> first window after 117 pixels with elem0=0, and 576 windows total.
- Two back-to-back frames: the second frame's first window is elem0=0, elem24=116. With CONV_WIN_COORD_EN defined, out_row/out_col = 0/0 there and 23/23 on out_last.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the 5x5 convolution datapath (window generator,
// dot-product MAC, max-pool).
//   IntSize   : pixel width in bits
//   KSize     : kernel edge, ArraySize = KSize*KSize window elements
//   ImgW/ImgH : image geometry, ColW/RowW the matching counter widths
//   win_idx   : packed-window element index for kernel position (r,c)
package conv_pkg;

   localparam int unsigned IntSize   = 8;
   localparam int unsigned KSize     = 5;
   localparam int unsigned ArraySize = KSize * KSize;
   localparam int unsigned ImgW      = 28;
   localparam int unsigned ImgH      = 28;
   localparam int unsigned ColW      = $clog2(ImgW);
   localparam int unsigned RowW      = $clog2(ImgH);

   // Element k of a packed window sits at bits [IntSize*k +: IntSize].
   function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
      return r * KSize + c;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row pixel delay line: tap_c presents the pixel written Depth enabled
// cycles earlier, i.e. the pixel directly above the one on din.
//   clk, rst : clock, synchronous active-high reset (pointer only)
//   en       : shift enable, one pixel per enabled cycle
//   din      : pixel entering the line
//   tap_c    : combinational read of the oldest pixel, valid before the write
module line_buffer #(
   parameter int unsigned Depth = 28,
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] tap_c
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  ptr;

   // Read-before-write on the same slot gives exactly Depth cycles of delay.
   assign tap_c = mem[ptr];

   // Circular write pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
      end
   end

   // Storage is left uninitialised; consumers gate stale data with counters.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator: accepts pixels in raster order and emits
// every fully-inside KSize x KSize window through a one-entry valid/ready stage.
//   clk, rst   : clock, synchronous active-high reset
//   in_pixel   : raster-order pixel, in_valid qualifies it
//   in_ready   : combinational, !out_valid || out_ready
//   out_window : packed window, element r*KSize+c at [IntSize*k +: IntSize]
//   out_valid  : out_window holds an unconsumed window, out_ready consumes it
//   out_last   : last window of the frame
// Optional (macro CONV_WIN_COORD_EN): out_row/out_col give the top-left pixel
// coordinate of out_window.
module conv_window_gen
   import conv_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [IntSize-1:0]           in_pixel,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [ArraySize*IntSize-1:0] out_window,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last
`ifdef CONV_WIN_COORD_EN
   ,
   output logic [RowW-1:0]              out_row,
   output logic [ColW-1:0]              out_col
`endif
);

   localparam int unsigned WinW = ArraySize * IntSize;

   logic               accept_c;
   logic               emit_c;
   logic               col_end_c;
   logic               row_end_c;
   logic [ColW-1:0]    col;
   logic [RowW-1:0]    row;
   logic [IntSize-1:0] lb_in_c  [KSize-1];
   logic [IntSize-1:0] tap_c    [KSize-1];
   logic [IntSize-1:0] col_in_c [KSize];
   logic [IntSize-1:0] win      [KSize][KSize];
   logic [WinW-1:0]    win_next_c;

   // Single-stage handshake: a stalled output freezes the whole pipeline.
   assign in_ready  = !out_valid || out_ready;
   assign accept_c  = in_valid && in_ready;
   assign col_end_c = (col == ColW'(ImgW - 1));
   assign row_end_c = (row == RowW'(ImgH - 1));
   assign emit_c    = accept_c && (row >= RowW'(KSize - 1)) && (col >= ColW'(KSize - 1));

   // Cascaded row delays: tap_c[i] is the pixel i+1 rows above the input.
   for (genvar i = 0; i < KSize - 1; i++) begin : g_lb
      if (i == 0) begin : g_head
         assign lb_in_c[i] = in_pixel;
      end else begin : g_tail
         assign lb_in_c[i] = tap_c[i-1];
      end
      line_buffer #(
         .Depth (ImgW),
         .Width (IntSize)
      ) u_lb (
         .clk   (clk),
         .rst   (rst),
         .en    (accept_c),
         .din   (lb_in_c[i]),
         .tap_c (tap_c[i])
      );
      assign col_in_c[KSize-2-i] = tap_c[i];
   end
   assign col_in_c[KSize-1] = in_pixel;

   // Next window: every row shifts one column left, new column enters right.
   always_comb begin
      win_next_c = '0;
      for (int unsigned r = 0; r < KSize; r++) begin
         for (int unsigned c = 0; c < KSize - 1; c++) begin
            win_next_c[IntSize*win_idx(r, c) +: IntSize] = win[r][c+1];
         end
         win_next_c[IntSize*win_idx(r, KSize-1) +: IntSize] = col_in_c[r];
      end
   end

   // Window register shifts on every accepted pixel, row-straddling included.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         for (int unsigned r = 0; r < KSize; r++) begin
            for (int unsigned c = 0; c < KSize; c++) begin
               win[r][c] <= win_next_c[IntSize*win_idx(r, c) +: IntSize];
            end
         end
      end
   end

   // Raster position of the next pixel to be accepted; frames run back-to-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept_c) begin
         if (col_end_c) begin
            col <= '0;
            row <= row_end_c ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Output stage: load on emission, clear once consumed, hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_window <= '0;
`ifdef CONV_WIN_COORD_EN
         out_row    <= '0;
         out_col    <= '0;
`endif
      end else if (emit_c) begin
         out_valid  <= 1'b1;
         out_last   <= row_end_c && col_end_c;
         out_window <= win_next_c;
`ifdef CONV_WIN_COORD_EN
         out_row    <= row - RowW'(KSize - 1);
         out_col    <= col - ColW'(KSize - 1);
`endif
      end else if (out_ready) begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end
   end

endmodule
